// File: rtl/logic_arbiter_if.sv
// logic_arbiter_if: request/response handshake bundle for the two requesters of logic_arbiter
interface logic_arbiter_if;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_x, req0_y, req1_x, req1_y;
    logic [1:0] req0_s, req1_s;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp0_data, rsp1_data;
    logic       busy;
    logic [7:0] gnt_cnt0, gnt_cnt1;
    modport master (
        output req0_valid, req0_x, req0_y, req0_s, req1_valid, req1_x, req1_y, req1_s,
               rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
               busy, gnt_cnt0, gnt_cnt1
    );
    modport slave (
        input  req0_valid, req0_x, req0_y, req0_s, req1_valid, req1_x, req1_y, req1_s,
               rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
               busy, gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/logic_arbiter.sv
// logic_arbiter: round-robin sharing of one 4-bit logical unit between two requesters.
// Optional saturating grant counters enabled by LOGIC_ARBITER_GNT_COUNT_EN.
module logic_arbiter_logical (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic [1:0] i_s,
    output logic [7:0] o_f
);
    assign o_f = (i_s == 2'd3) ? ~{i_y, i_x} :
                 {4'b0, (i_s == 2'd0) ? (i_x & i_y) : (i_s == 2'd1) ? (i_x | i_y) : (i_x ^ i_y)};
endmodule

module logic_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    logic_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     r_state;
    logic       r_owner, r_ptr, r_busy;
    logic [3:0] r_x, r_y;
    logic [1:0] r_s;
    logic       r_rsp0_valid, r_rsp1_valid;
    logic [7:0] r_rsp0_data, r_rsp1_data;
    logic       w_any, w_gnt, w_accept, w_hs;
    logic [7:0] w_f;

    assign w_any    = bus.req0_valid | bus.req1_valid;
    assign w_gnt    = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
    // ready is gated by rst_n so it reads 0 while reset is held
    assign w_accept = rst_n && (r_state == IDLE) && w_any;
    assign w_hs     = (r_rsp0_valid & bus.rsp0_ready) | (r_rsp1_valid & bus.rsp1_ready);

    assign bus.req0_ready = w_accept && !w_gnt;
    assign bus.req1_ready = w_accept && w_gnt;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_data  = r_rsp0_data;
    assign bus.rsp1_data  = r_rsp1_data;
    assign bus.busy       = r_busy;

    logic_arbiter_logical u_logical (.i_x(r_x), .i_y(r_y), .i_s(r_s), .o_f(w_f));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_ptr        <= RR_INIT;
            r_busy       <= 1'b0;
            r_x          <= 4'h0;
            r_y          <= 4'h0;
            r_s          <= 2'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= 8'h00;
            r_rsp1_data  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_x     <= w_gnt ? bus.req1_x : bus.req0_x;
                    r_y     <= w_gnt ? bus.req1_y : bus.req0_y;
                    r_s     <= w_gnt ? bus.req1_s : bus.req0_s;
                    r_owner <= w_gnt;
                    r_busy  <= 1'b1;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_rsp0_valid <= !r_owner;
                    r_rsp1_valid <= r_owner;
                    r_rsp0_data  <= r_owner ? 8'h00 : w_f;
                    r_rsp1_data  <= r_owner ? w_f : 8'h00;
                    r_state      <= RESP;
                end
                RESP: if (w_hs) begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_rsp0_data  <= 8'h00;
                    r_rsp1_data  <= 8'h00;
                    r_busy       <= 1'b0;
                    r_ptr        <= !r_owner;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_ARBITER_GNT_COUNT_EN
    logic [7:0] r_gnt_cnt0, r_gnt_cnt1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_cnt0 <= 8'h00;
            r_gnt_cnt1 <= 8'h00;
        end else begin
            if (bus.req0_ready && r_gnt_cnt0 != 8'hFF) r_gnt_cnt0 <= r_gnt_cnt0 + 8'd1;
            if (bus.req1_ready && r_gnt_cnt1 != 8'hFF) r_gnt_cnt1 <= r_gnt_cnt1 + 8'd1;
        end
    end
    assign bus.gnt_cnt0 = r_gnt_cnt0;
    assign bus.gnt_cnt1 = r_gnt_cnt1;
`else
    assign bus.gnt_cnt0 = 8'h00;
    assign bus.gnt_cnt1 = 8'h00;
`endif
endmodule

// File: tb/tb_logic_arbiter.sv
// tb_logic_arbiter: directed self-checking bench for logic_arbiter
module tb_logic_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   g = 0;

    always #5 clk = ~clk;

    logic_arbiter_if bus();
    logic_arbiter #(.RR_INIT(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #3;
    endtask

    initial begin
        bus.req0_valid = 1'b1; bus.req0_x = 4'h0; bus.req0_y = 4'h0; bus.req0_s = 2'd0;
        bus.req1_valid = 1'b1; bus.req1_x = 4'h0; bus.req1_y = 4'h0; bus.req1_s = 2'd0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        #12;
        chk("rst_req0_ready", {7'b0, bus.req0_ready}, 8'd0);
        chk("rst_req1_ready", {7'b0, bus.req1_ready}, 8'd0);
        chk("rst_busy", {7'b0, bus.busy}, 8'd0);
        chk("rst_rsp0_valid", {7'b0, bus.rsp0_valid}, 8'd0);
        chk("rst_rsp1_valid", {7'b0, bus.rsp1_valid}, 8'd0);
        chk("rst_rsp0_data", bus.rsp0_data, 8'h00);
        chk("rst_rsp1_data", bus.rsp1_data, 8'h00);
        chk("rst_gnt_cnt0", bus.gnt_cnt0, 8'h00);
        chk("rst_gnt_cnt1", bus.gnt_cnt1, 8'h00);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cyc;
        // single AND request from requester 0
        bus.req0_x = 4'hC; bus.req0_y = 4'hA; bus.req0_s = 2'd0; bus.req0_valid = 1'b1;
        #1;
        chk("and_req0_ready", {7'b0, bus.req0_ready}, 8'd1);
        chk("and_req1_ready", {7'b0, bus.req1_ready}, 8'd0);
        chk("and_busy_c0", {7'b0, bus.busy}, 8'd0);
        cyc; bus.req0_valid = 1'b0; #1;
        chk("and_busy_c1", {7'b0, bus.busy}, 8'd1);
        chk("and_rsp0_valid_c1", {7'b0, bus.rsp0_valid}, 8'd0);
        cyc;
        chk("and_rsp0_valid_c2", {7'b0, bus.rsp0_valid}, 8'd1);
        chk("and_rsp0_data", bus.rsp0_data, 8'h08);
        chk("and_busy_c2", {7'b0, bus.busy}, 8'd1);
        cyc;
        chk("and_busy_c3", {7'b0, bus.busy}, 8'd0);
        chk("and_rsp0_valid_c3", {7'b0, bus.rsp0_valid}, 8'd0);
        // NOT from requester 1
        bus.req1_x = 4'h3; bus.req1_y = 4'h5; bus.req1_s = 2'd3; bus.req1_valid = 1'b1;
        #1;
        chk("not_req1_ready", {7'b0, bus.req1_ready}, 8'd1);
        chk("not_rsp0_valid_c0", {7'b0, bus.rsp0_valid}, 8'd0);
        cyc; bus.req1_valid = 1'b0; #1;
        chk("not_rsp0_valid_c1", {7'b0, bus.rsp0_valid}, 8'd0);
        cyc;
        chk("not_rsp1_valid", {7'b0, bus.rsp1_valid}, 8'd1);
        chk("not_rsp1_data", bus.rsp1_data, 8'hAC);
        chk("not_rsp0_valid_c2", {7'b0, bus.rsp0_valid}, 8'd0);
        chk("not_rsp0_data", bus.rsp0_data, 8'h00);
        cyc;
        chk("not_rsp1_valid_c3", {7'b0, bus.rsp1_valid}, 8'd0);
        // contention: both valid for six operations
        bus.req0_x = 4'h1; bus.req0_y = 4'h2; bus.req0_s = 2'd1; bus.req0_valid = 1'b1;
        bus.req1_x = 4'hF; bus.req1_y = 4'h5; bus.req1_s = 2'd2; bus.req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_req0_ready", {7'b0, bus.req0_ready}, (i % 2 == 0) ? 8'd1 : 8'd0);
            chk("cont_req1_ready", {7'b0, bus.req1_ready}, (i % 2 == 0) ? 8'd0 : 8'd1);
            cyc; cyc;
            chk("cont_rsp0_valid", {7'b0, bus.rsp0_valid}, (i % 2 == 0) ? 8'd1 : 8'd0);
            chk("cont_rsp1_valid", {7'b0, bus.rsp1_valid}, (i % 2 == 0) ? 8'd0 : 8'd1);
            chk("cont_rsp0_data", bus.rsp0_data, (i % 2 == 0) ? 8'h03 : 8'h00);
            chk("cont_rsp1_data", bus.rsp1_data, (i % 2 == 0) ? 8'h00 : 8'h0A);
            cyc;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; #1;
        chk("cont_idle_busy", {7'b0, bus.busy}, 8'd0);
        // back-pressure on requester 0 while requester 1 waits
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp0_ready = 1'b0; #1;
        chk("bp_req0_ready", {7'b0, bus.req0_ready}, 8'd1);
        cyc; bus.req0_valid = 1'b0;
        cyc;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp0_valid", {7'b0, bus.rsp0_valid}, 8'd1);
            chk("bp_rsp0_data", bus.rsp0_data, 8'h03);
            chk("bp_req1_ready", {7'b0, bus.req1_ready}, 8'd0);
            cyc;
        end
        bus.rsp0_ready = 1'b1; #1;
        chk("bp_req1_ready_hs", {7'b0, bus.req1_ready}, 8'd0);
        cyc;
        chk("bp_req1_ready_after", {7'b0, bus.req1_ready}, 8'd1);
        chk("bp_busy_after", {7'b0, bus.busy}, 8'd0);
        cyc; bus.req1_valid = 1'b0;
        cyc;
        chk("bp_rsp1_valid", {7'b0, bus.rsp1_valid}, 8'd1);
        chk("bp_rsp1_data", bus.rsp1_data, 8'h0A);
        cyc;
        chk("bp_busy_end", {7'b0, bus.busy}, 8'd0);
        // XOR from requester 0 leaves the pointer at requester 1
        bus.req0_x = 4'h6; bus.req0_y = 4'h3; bus.req0_s = 2'd2; bus.req0_valid = 1'b1; #1;
        chk("xor_req0_ready", {7'b0, bus.req0_ready}, 8'd1);
        cyc; bus.req0_valid = 1'b0;
        cyc;
        chk("xor_rsp0_data", bus.rsp0_data, 8'h05);
        cyc;
        // reset during EXEC
        bus.req0_x = 4'hC; bus.req0_y = 4'hA; bus.req0_s = 2'd0; bus.req0_valid = 1'b1; #1;
        chk("mr_req0_ready", {7'b0, bus.req0_ready}, 8'd1);
        cyc; bus.req0_valid = 1'b0; #1;
        chk("mr_busy_exec", {7'b0, bus.busy}, 8'd1);
        rst_n = 1'b0; #1;
        chk("mr_busy", {7'b0, bus.busy}, 8'd0);
        chk("mr_rsp0_valid", {7'b0, bus.rsp0_valid}, 8'd0);
        chk("mr_rsp1_valid", {7'b0, bus.rsp1_valid}, 8'd0);
        chk("mr_rsp0_data", bus.rsp0_data, 8'h00);
        chk("mr_rsp1_data", bus.rsp1_data, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        cyc;
        chk("mr_rsp0_valid_after", {7'b0, bus.rsp0_valid}, 8'd0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; #1;
        chk("mr_tie_req0", {7'b0, bus.req0_ready}, 8'd1);
        chk("mr_tie_req1", {7'b0, bus.req1_ready}, 8'd0);
        // 300 back-to-back grants to requester 0
        bus.req1_valid = 1'b0; bus.rsp0_ready = 1'b1;
        for (int c = 0; c < 1200 && g < 300; c++) begin
            if (bus.req0_ready) g++;
            cyc;
            if (g == 300) bus.req0_valid = 1'b0;
        end
        chk("cnt_grants_seen", {7'b0, g == 300}, 8'd1);
        cyc; cyc; #1;
        chk("cnt_busy_end", {7'b0, bus.busy}, 8'd0);
`ifdef LOGIC_ARBITER_GNT_COUNT_EN
        chk("cnt_gnt_cnt0", bus.gnt_cnt0, 8'hFF);
        chk("cnt_gnt_cnt1", bus.gnt_cnt1, 8'h00);
`else
        chk("cnt_gnt_cnt0_off", bus.gnt_cnt0, 8'h00);
        chk("cnt_gnt_cnt1_off", bus.gnt_cnt1, 8'h00);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
